// File: rtl/stack_cpu.sv
// 16-bit two-stack Forth-style core: one instruction per clock, T in a register,
// N and R read from the stack RAMs. Define STACK_CPU_DATA_RAM_EN to add a 256x16 data RAM.
module stack_cpu #(
  parameter string       PROG_FILE    = "prog.hex",
  parameter int unsigned PROG_WORDS   = 256,
  parameter int unsigned DSTACK_DEPTH = 16,
  parameter int unsigned RSTACK_DEPTH = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic [15:0] o_ip,
  output logic [15:0] o_t,
  output logic [15:0] o_r,
  output logic [3:0]  o_alu_op
);

  localparam int unsigned AW = (PROG_WORDS > 1) ? $clog2(PROG_WORDS) : 1;
  localparam int unsigned DW = $clog2(DSTACK_DEPTH);
  localparam int unsigned RW = $clog2(RSTACK_DEPTH);

  typedef enum logic [2:0] {
    CLS_JMP  = 3'b000,
    CLS_JZ   = 3'b001,
    CLS_CALL = 3'b010,
    CLS_ALU  = 3'b011,
    CLS_LIT  = 3'b100
  } cls_t;

  typedef enum logic [3:0] {
    OP_T, OP_N, OP_ADD, OP_AND, OP_OR, OP_XOR, OP_INV, OP_EQ,
    OP_LT, OP_RSH, OP_DEC, OP_R, OP_LOAD, OP_LSH, OP_DEPTH, OP_ULT
  } op_t;

  logic [15:0] rom  [PROG_WORDS];
  logic [15:0] dmem [DSTACK_DEPTH];
  logic [15:0] rmem [RSTACK_DEPTH];

  logic [15:0]   ip, t;
  logic [DW-1:0] dsp, dsp_nxt;
  logic [RW-1:0] rsp, rsp_nxt;

  logic [AW-1:0] rom_addr;
  logic [15:0]   fetch, insn, n, r, alu, target;
  logic [15:0]   ip_nxt, t_nxt, rwdata;
  logic          dwe, rwe;
  cls_t          cls;
  op_t           op;
  logic [1:0]    unused_rsvd;

`ifdef STACK_CPU_DATA_RAM_EN
  logic [15:0] dram [256];
  logic        dram_we;
`endif

  always_comb begin
    fetch    = ip + 16'd1;
    rom_addr = AW'(32'(fetch) % PROG_WORDS);
    insn     = rom[rom_addr];
    n        = dmem[dsp];
    r        = rmem[rsp];
    cls      = insn[15] ? CLS_LIT : cls_t'({1'b0, insn[14:13]});
    op       = op_t'(insn[11:8]);
    // IP holds the address of the last executed instruction, so a branch to a stores a-1.
    target   = {3'b000, insn[12:0]} - 16'd1;
    unused_rsvd = {insn[5], insn[4]};
  end

  always_comb begin
    alu = t;
    case (op)
      OP_T:     alu = t;
      OP_N:     alu = n;
      OP_ADD:   alu = t + n;
      OP_AND:   alu = t & n;
      OP_OR:    alu = t | n;
      OP_XOR:   alu = t ^ n;
      OP_INV:   alu = ~t;
      OP_EQ:    alu = {16{n == t}};
      OP_LT:    alu = {16{$signed(n) < $signed(t)}};
      OP_RSH:   alu = n >> t[3:0];
      OP_DEC:   alu = t - 16'd1;
      OP_R:     alu = r;
`ifdef STACK_CPU_DATA_RAM_EN
      OP_LOAD:  alu = dram[t[7:0]];
`else
      OP_LOAD:  alu = '0;
`endif
      OP_LSH:   alu = n << t[3:0];
      OP_DEPTH: alu = {8'(rsp), 8'(dsp)};
      OP_ULT:   alu = {16{n < t}};
      default:  alu = t;
    endcase
  end

  always_comb begin
    ip_nxt  = fetch;
    t_nxt   = t;
    dsp_nxt = dsp;
    rsp_nxt = rsp;
    dwe     = 1'b0;
    rwe     = 1'b0;
    rwdata  = t;
`ifdef STACK_CPU_DATA_RAM_EN
    dram_we = 1'b0;
`endif
    case (cls)
      CLS_LIT: begin
        t_nxt   = {1'b0, insn[14:0]};
        dsp_nxt = dsp + DW'(1);
        dwe     = 1'b1;
      end
      CLS_JMP: ip_nxt = target;
      CLS_JZ: begin
        if (t == '0) ip_nxt = target;
        t_nxt   = n;
        dsp_nxt = dsp - DW'(1);
      end
      CLS_CALL: begin
        ip_nxt  = target;
        rsp_nxt = rsp + RW'(1);
        rwe     = 1'b1;
        rwdata  = fetch + 16'd1;
      end
      CLS_ALU: begin
        if (insn[12]) ip_nxt = r - 16'd1;
        t_nxt = alu;
        case (insn[1:0])
          2'b01:   dsp_nxt = dsp + DW'(1);
          2'b11:   dsp_nxt = dsp - DW'(1);
          default: dsp_nxt = dsp;
        endcase
        case (insn[3:2])
          2'b01:   rsp_nxt = rsp + RW'(1);
          2'b11:   rsp_nxt = rsp - RW'(1);
          default: rsp_nxt = rsp;
        endcase
        // Stack writes land at the post-delta pointer, so dup (T->N, d+1) pushes T.
        dwe    = insn[7];
        rwe    = insn[6];
        rwdata = t;
`ifdef STACK_CPU_DATA_RAM_EN
        dram_we = insn[5];
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ip  <= 16'hFFFF;
      t   <= '0;
      dsp <= '0;
      rsp <= '0;
    end else begin
      ip  <= ip_nxt;
      t   <= t_nxt;
      dsp <= dsp_nxt;
      rsp <= rsp_nxt;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset && dwe) dmem[dsp_nxt] <= t;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset && rwe) rmem[rsp_nxt] <= rwdata;
  end

`ifdef STACK_CPU_DATA_RAM_EN
  always_ff @(posedge i_clock) begin
    if (!i_reset && dram_we) dram[t[7:0]] <= n;
  end
`endif

  always_comb begin
    o_ip     = ip;
    o_t      = t;
    o_r      = r;
    o_alu_op = (cls == CLS_ALU) ? insn[11:8] : 4'h0;
  end

endmodule

// File: tb/tb_stack_cpu.sv
// Directed-vector bench for stack_cpu: programs are written into the ROM array,
// then T/IP/R/ALU-op are compared against hand-computed values after each step.
module tb_stack_cpu;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] o_ip, o_t, o_r;
  logic [3:0]  o_alu_op;

  int vectors = 0;
  int miscompares = 0;

  stack_cpu #(
    .PROG_FILE   (""),
    .PROG_WORDS  (256),
    .DSTACK_DEPTH(16),
    .RSTACK_DEPTH(16)
  ) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .o_ip    (o_ip),
    .o_t     (o_t),
    .o_r     (o_r),
    .o_alu_op(o_alu_op)
  );

  always #5 i_clock = ~i_clock;

  // ALU walk: instruction, T after it executes, ALU op field while it executes.
  logic [15:0] seq_insn [29] = '{
    16'h8003, 16'h800A, 16'h6500, 16'h6300, 16'h6400, 16'h6700, 16'h6800, 16'h6A00,
    16'h6F00, 16'h6800, 16'h6600, 16'h6100, 16'h6D00, 16'h6900, 16'h6A00, 16'h8054,
    16'h6900, 16'h6081, 16'h6203, 16'h6044, 16'h8000, 16'h6B00, 16'h6E00, 16'h6103,
    16'h6E00, 16'h6600, 16'h6081, 16'h8000, 16'h6800};
  logic [15:0] seq_t [29] = '{
    16'h0003, 16'h000A, 16'h0009, 16'h0001, 16'h0003, 16'hFFFF, 16'h0000, 16'hFFFF,
    16'hFFFF, 16'h0000, 16'hFFFF, 16'h0003, 16'h0018, 16'h0000, 16'hFFFF, 16'h0054,
    16'h0FFF, 16'h0FFF, 16'h1FFE, 16'h1FFE, 16'h0000, 16'h1FFE, 16'h0104, 16'h1FFE,
    16'h0103, 16'hFEFC, 16'hFEFC, 16'h0000, 16'hFFFF};
  logic [3:0] seq_op [29] = '{
    4'h0, 4'h0, 4'h5, 4'h3, 4'h4, 4'h7, 4'h8, 4'hA,
    4'hF, 4'h8, 4'h6, 4'h1, 4'hD, 4'h9, 4'hA, 4'h0,
    4'h9, 4'h0, 4'h2, 4'h0, 4'h0, 4'hB, 4'hE, 4'h1,
    4'hE, 4'h6, 4'h0, 4'h0, 4'h8};

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) dut.rom[i] = 16'h0000;
  endtask

  task automatic put(input int addr, input logic [15:0] w);
    dut.rom[addr] = w;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    step();
    check_eq("reset_ip", o_ip, 16'hFFFF);
    check_eq("reset_t", o_t, 16'h0000);
    i_reset = 1'b0;
  endtask

  initial begin
    // Add: two literals then add with d-1.
    clear_rom();
    put(0, 16'h8005); put(1, 16'h8003); put(2, 16'h6203);
    do_reset();
    step(); step(); step();
    check_eq("add_t", o_t, 16'h0008);
    check_eq("add_ip", o_ip, 16'h0002);

    // Unconditional jump.
    clear_rom();
    put(0, 16'h0010); put(16, 16'h8042);
    do_reset();
    step();
    check_eq("jmp_ip_mid", o_ip, 16'h000F);
    step();
    check_eq("jmp_t", o_t, 16'h0042);
    check_eq("jmp_ip", o_ip, 16'h0010);

    // Conditional jump taken (T==0).
    clear_rom();
    put(0, 16'h8077); put(1, 16'h8000); put(2, 16'h2014); put(20, 16'h6E00);
    do_reset();
    step(); step(); step();
    check_eq("jz_take_ip", o_ip, 16'h0013);
    check_eq("jz_take_t", o_t, 16'h0077);
    step();
    check_eq("jz_take_ip2", o_ip, 16'h0014);
    check_eq("jz_take_depth", o_t, 16'h0001);

    // Conditional jump not taken (T!=0).
    clear_rom();
    put(0, 16'h8077); put(1, 16'h8001); put(2, 16'h2014); put(3, 16'h6E00);
    do_reset();
    step(); step(); step();
    check_eq("jz_fall_ip", o_ip, 16'h0002);
    check_eq("jz_fall_t", o_t, 16'h0077);
    step();
    check_eq("jz_fall_ip2", o_ip, 16'h0003);
    check_eq("jz_fall_depth", o_t, 16'h0001);

    // Call/return, then reset mid-run and repeat.
    clear_rom();
    put(0, 16'h4008); put(1, 16'h8055); put(2, 16'h6E00); put(8, 16'h700C);
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      step();
      check_eq("call_ip", o_ip, 16'h0007);
      check_eq("call_r", o_r, 16'h0001);
      check_eq("call_aluop", {12'h000, o_alu_op}, 16'h0000);
      step();
      check_eq("ret_ip", o_ip, 16'h0000);
      step();
      check_eq("ret_lit_t", o_t, 16'h0055);
      check_eq("ret_lit_ip", o_ip, 16'h0001);
      step();
      check_eq("ret_depth", o_t, 16'h0001);
      if (pass == 0) begin
        i_reset = 1'b1;
        step();
        check_eq("midrst_ip", o_ip, 16'hFFFF);
        check_eq("midrst_t", o_t, 16'h0000);
        i_reset = 1'b0;
      end
    end

    // Return with simultaneous T->R: target is old R, write lands at rsp+1.
    clear_rom();
    put(0, 16'h4008); put(1, 16'h6B00); put(2, 16'h6E00);
    put(8, 16'h8099); put(9, 16'h7044);
    do_reset();
    step(); step(); step();
    check_eq("tr_ret_ip", o_ip, 16'h0000);
    check_eq("tr_ret_r", o_r, 16'h0099);
    step();
    check_eq("tr_r_t", o_t, 16'h0099);
    step();
    check_eq("tr_depth", o_t, 16'h0201);
    check_eq("tr_ip", o_ip, 16'h0002);

    // ALU walk.
    clear_rom();
    for (int i = 0; i < 29; i++) put(i, seq_insn[i]);
    do_reset();
    for (int i = 0; i < 29; i++) begin
      check_eq($sformatf("alu_op%0d", i), {12'h000, o_alu_op}, {12'h000, seq_op[i]});
      step();
      check_eq($sformatf("alu_t%0d", i), o_t, seq_t[i]);
      if (i == 19) check_eq("alu_r", o_r, 16'h1FFE);
    end
    check_eq("alu_ip", o_ip, 16'h001C);

    // Data RAM store then load.
    clear_rom();
    put(0, 16'h9234); put(1, 16'h8005); put(2, 16'h6023); put(3, 16'h8005); put(4, 16'h6C00);
    do_reset();
    step(); step(); step();
    check_eq("store_t", o_t, 16'h0005);
    step(); step();
`ifdef STACK_CPU_DATA_RAM_EN
    check_eq("load_t", o_t, 16'h1234);
`else
    check_eq("load_t", o_t, 16'h0000);
`endif
    check_eq("load_ip", o_ip, 16'h0004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
